// File: rtl/tm1638_responder.sv
// TM1638-compatible serial responder: decodes host command/data frames into a display RAM and
// shifts key-scan bytes back on read. Optional macro TM1638_RESP_FIXED_ADDR_EN enables fixed-address writes.
module tm1638_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic         mclk,
    input  logic         rst,
    input  logic         stb_in,
    input  logic         clk_in,
    input  logic         dio_in,
    output logic         dio_out,
    output logic         dio_oe,
    input  logic [31:0]  key_data,
    output logic [127:0] disp_ram,
    output logic         disp_on,
    output logic [2:0]   disp_bright,
    output logic         frame_done,
    output logic [2:0]   state
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_WDATA  = 3'd2;
    localparam logic [2:0] S_RDATA  = 3'd3;
    localparam logic [2:0] S_IGNORE = 3'd4;

    logic [SYNC_STAGES-1:0] stb_sync_q, stb_sync_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dio_sync_q, dio_sync_d;
    logic       stb_prev_q, clk_prev_q;
    logic [2:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       byte_done_q, byte_done_d;
    logic [3:0] addr_q, addr_d;
    logic       read_mode_q, read_mode_d;
    logic       fixed_q, fixed_d;
    logic [31:0] key_q, key_d;
    logic [5:0] rd_cnt_q, rd_cnt_d;
    logic       dio_oe_q, dio_oe_d;
    logic       dio_out_q, dio_out_d;
    logic [127:0] disp_q, disp_d;
    logic       disp_on_q, disp_on_d;
    logic [2:0] bright_q, bright_d;
    logic       frame_done_q, frame_done_d;

    logic stb_s, clk_s, dio_s;
    logic stb_rise, stb_fall, clk_rise, clk_fall;

    assign stb_s    = stb_sync_q[SYNC_STAGES-1];
    assign clk_s    = clk_sync_q[SYNC_STAGES-1];
    assign dio_s    = dio_sync_q[SYNC_STAGES-1];
    assign stb_rise = ~stb_prev_q & stb_s;
    assign stb_fall = stb_prev_q & ~stb_s;
    assign clk_rise = ~clk_prev_q & clk_s;
    assign clk_fall = clk_prev_q & ~clk_s;

    always_comb begin
        stb_sync_d   = {stb_sync_q[SYNC_STAGES-2:0], stb_in};
        clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], clk_in};
        dio_sync_d   = {dio_sync_q[SYNC_STAGES-2:0], dio_in};
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_done_d  = 1'b0;
        addr_d       = addr_q;
        read_mode_d  = read_mode_q;
        fixed_d      = fixed_q;
        key_d        = key_q;
        rd_cnt_d     = rd_cnt_q;
        dio_oe_d     = dio_oe_q;
        dio_out_d    = dio_out_q;
        disp_d       = disp_q;
        disp_on_d    = disp_on_q;
        bright_d     = bright_q;
        frame_done_d = 1'b0;

        // A closing strobe overrides any clock edge or pending byte in the same cycle.
        if (stb_rise) begin
            if (state_q != S_IDLE) begin
                state_d      = S_IDLE;
                dio_oe_d     = 1'b0;
                dio_out_d    = 1'b0;
                frame_done_d = 1'b1;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (stb_fall) begin
                        state_d   = S_CMD;
                        bit_cnt_d = 3'd0;
                        shift_d   = 8'd0;
                    end
                end
                S_CMD, S_WDATA: begin
                    if (byte_done_q) begin
                        if (state_q == S_WDATA) begin
                            disp_d[{addr_q, 3'b000} +: 8] = shift_q;
                            if (!fixed_q) addr_d = addr_q + 4'd1;
                        end else begin
                            case (shift_q[7:6])
                                2'b01: begin
                                    read_mode_d = shift_q[1];
`ifdef TM1638_RESP_FIXED_ADDR_EN
                                    fixed_d = shift_q[2];
`else
                                    fixed_d = 1'b0;
`endif
                                    if (shift_q[1]) begin
                                        state_d  = S_RDATA;
                                        key_d    = key_data;
                                        rd_cnt_d = 6'd0;
                                    end else begin
                                        state_d = S_IGNORE;
                                    end
                                end
                                2'b10: begin
                                    disp_on_d = shift_q[3];
                                    bright_d  = shift_q[2:0];
                                    state_d   = S_IGNORE;
                                end
                                2'b11: begin
                                    addr_d  = shift_q[3:0];
                                    state_d = read_mode_q ? S_IGNORE : S_WDATA;
                                end
                                default: state_d = S_IGNORE;
                            endcase
                        end
                    end else if (clk_rise) begin
                        shift_d     = {dio_s, shift_q[7:1]};
                        bit_cnt_d   = bit_cnt_q + 3'd1;
                        byte_done_d = (bit_cnt_q == 3'd7);
                    end
                end
                S_RDATA: begin
                    // rd_cnt saturates at 32 so later clocks leave DIO released.
                    if (clk_fall) begin
                        if (rd_cnt_q < 6'd32) begin
                            dio_oe_d  = 1'b1;
                            dio_out_d = key_q[rd_cnt_q[4:0]];
                            rd_cnt_d  = rd_cnt_q + 6'd1;
                        end else begin
                            dio_oe_d  = 1'b0;
                            dio_out_d = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            stb_sync_q   <= '1;
            clk_sync_q   <= '1;
            dio_sync_q   <= '0;
            stb_prev_q   <= 1'b1;
            clk_prev_q   <= 1'b1;
            state_q      <= S_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            byte_done_q  <= 1'b0;
            addr_q       <= 4'd0;
            read_mode_q  <= 1'b0;
            fixed_q      <= 1'b0;
            key_q        <= 32'd0;
            rd_cnt_q     <= 6'd0;
            dio_oe_q     <= 1'b0;
            dio_out_q    <= 1'b0;
            disp_q       <= 128'd0;
            disp_on_q    <= 1'b0;
            bright_q     <= 3'd0;
            frame_done_q <= 1'b0;
        end else begin
            stb_sync_q   <= stb_sync_d;
            clk_sync_q   <= clk_sync_d;
            dio_sync_q   <= dio_sync_d;
            stb_prev_q   <= stb_s;
            clk_prev_q   <= clk_s;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_done_q  <= byte_done_d;
            addr_q       <= addr_d;
            read_mode_q  <= read_mode_d;
            fixed_q      <= fixed_d;
            key_q        <= key_d;
            rd_cnt_q     <= rd_cnt_d;
            dio_oe_q     <= dio_oe_d;
            dio_out_q    <= dio_out_d;
            disp_q       <= disp_d;
            disp_on_q    <= disp_on_d;
            bright_q     <= bright_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign dio_out     = dio_out_q & dio_oe_q;
    assign dio_oe      = dio_oe_q;
    assign disp_ram    = disp_q;
    assign disp_on     = disp_on_q;
    assign disp_bright = bright_q;
    assign frame_done  = frame_done_q;
    assign state       = state_q;
endmodule

// File: tb/tb_tm1638_responder.sv
// Directed bench for tm1638_responder: host frames are bit-banged at 1/16 of mclk and
// results are compared with hand-computed display RAM, control and key-read values.
module tb_tm1638_responder;
    logic         mclk = 1'b0;
    logic         rst;
    logic         stb_in, clk_in, dio_in;
    logic         dio_out, dio_oe;
    logic [31:0]  key_data;
    logic [127:0] disp_ram;
    logic         disp_on;
    logic [2:0]   disp_bright;
    logic         frame_done;
    logic [2:0]   state;

    int checks = 0;
    int failures = 0;
    int fd_cnt = 0;
    bit oe_seen = 1'b0;
    logic [127:0] exp_ram;

    tm1638_responder #(.SYNC_STAGES(2)) dut (
        .mclk(mclk), .rst(rst), .stb_in(stb_in), .clk_in(clk_in), .dio_in(dio_in),
        .dio_out(dio_out), .dio_oe(dio_oe), .key_data(key_data), .disp_ram(disp_ram),
        .disp_on(disp_on), .disp_bright(disp_bright), .frame_done(frame_done), .state(state)
    );

    always #5 mclk = ~mclk;

    always @(negedge mclk) begin
        if (frame_done) fd_cnt++;
        if (dio_oe) oe_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic frame_start();
        stb_in = 1'b0;
        #160;
    endtask

    task automatic frame_end();
        clk_in = 1'b1;
        stb_in = 1'b1;
        #300;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            clk_in = 1'b0;
            dio_in = b[i];
            #80;
            clk_in = 1'b1;
            #80;
        end
    endtask

    task automatic cmd_frame(input logic [7:0] b);
        frame_start();
        send_bits(b, 8);
        frame_end();
    endtask

    task automatic read_bits(input int n, output logic [31:0] word, output int oe_cnt);
        word = '0;
        oe_cnt = 0;
        for (int i = 0; i < n; i++) begin
            clk_in = 1'b0;
            #80;
            word[i] = dio_out;
            if (dio_oe) oe_cnt++;
            clk_in = 1'b1;
            #80;
        end
    endtask

    initial begin
        logic [31:0] rd_word;
        int oe_cnt;
        int fd_base;
        logic [7:0] wr_bytes [3];

        rst = 1'b1; stb_in = 1'b1; clk_in = 1'b1; dio_in = 1'b0;
        key_data = 32'h0;
        exp_ram = '0;
        #23;
        check("rst_state", state, 3'd0);
        check("rst_oe", dio_oe, 1'b0);
        check("rst_out", dio_out, 1'b0);
        check("rst_ram", disp_ram, 128'h0);
        check("rst_on_bright", {disp_on, disp_bright}, 4'h0);
        check("rst_frame_done", frame_done, 1'b0);
        rst = 1'b0;
        #100;

        // Sequential write of 0x00..0x0F from address 0.
        fd_cnt = 0;
        cmd_frame(8'h40);
        frame_start();
        send_bits(8'hC0, 8);
        for (int n = 0; n < 16; n++) begin
            send_bits(8'(n), 8);
            exp_ram[8*n +: 8] = 8'(n);
        end
        frame_end();
        check("seq_ram", disp_ram, exp_ram);
        check("seq_frame_done", fd_cnt, 2);

        // Display control.
        oe_seen = 1'b0;
        cmd_frame(8'h8F);
        check("disp_on", disp_on, 1'b1);
        check("disp_bright", disp_bright, 3'd7);
        check("disp_ram_kept", disp_ram, exp_ram);
        check("disp_no_oe", oe_seen, 1'b0);

        // Key read; key_data changes after capture must not leak.
        key_data = 32'h8040_2001;
        frame_start();
        send_bits(8'h42, 8);
        #100;
        key_data = 32'hFFFF_FFFF;
        read_bits(32, rd_word, oe_cnt);
        check("key_byte0", rd_word[7:0], 8'h01);
        check("key_byte1", rd_word[15:8], 8'h20);
        check("key_byte2", rd_word[23:16], 8'h40);
        check("key_byte3", rd_word[31:24], 8'h80);
        check("key_oe_bits", oe_cnt, 32);
        clk_in = 1'b0;
        #80;
        check("key_oe_release", dio_oe, 1'b0);
        check("key_out_released", dio_out, 1'b0);
        clk_in = 1'b1;
        #80;
        frame_end();
        check("key_idle", state, 3'd0);

        // Address wrap from 0xE.
        cmd_frame(8'h40);
        frame_start();
        send_bits(8'hCE, 8);
        wr_bytes = '{8'hAA, 8'hBB, 8'hCC};
        foreach (wr_bytes[i]) send_bits(wr_bytes[i], 8);
        frame_end();
        exp_ram[8*14 +: 8] = 8'hAA;
        exp_ram[8*15 +: 8] = 8'hBB;
        exp_ram[8*0  +: 8] = 8'hCC;
        check("wrap_ram", disp_ram, exp_ram);

        // Fixed-address data command.
        cmd_frame(8'h44);
        frame_start();
        send_bits(8'hC3, 8);
        send_bits(8'h11, 8);
        send_bits(8'h22, 8);
        frame_end();
`ifdef TM1638_RESP_FIXED_ADDR_EN
        exp_ram[8*3 +: 8] = 8'h22;
`else
        exp_ram[8*3 +: 8] = 8'h11;
        exp_ram[8*4 +: 8] = 8'h22;
`endif
        check("fixed_ram", disp_ram, exp_ram);

        // Partial byte aborted by strobe: no write, frame_done still pulses.
        cmd_frame(8'h40);
        fd_base = fd_cnt;
        frame_start();
        send_bits(8'hC5, 8);
        send_bits(8'hFF, 5);
        frame_end();
        check("partial_ram", disp_ram, exp_ram);
        check("partial_frame_done", fd_cnt - fd_base, 1);

        // Address set while in read mode is ignored; command 0x00 is ignored too.
        cmd_frame(8'h42);
        frame_start();
        send_bits(8'hC0, 8);
        send_bits(8'h55, 8);
        frame_end();
        cmd_frame(8'h00);
        check("readmode_no_write", disp_ram, exp_ram);
        check("cmd00_no_change", {disp_on, disp_bright}, 4'hF);

        // Reset in the middle of a key read.
        frame_start();
        send_bits(8'h42, 8);
        read_bits(10, rd_word, oe_cnt);
        clk_in = 1'b0;
        #80;
        check("mid_read_oe", dio_oe, 1'b1);
        fd_base = fd_cnt;
        rst = 1'b1;
        #1;
        check("rst_mid_oe", dio_oe, 1'b0);
        check("rst_mid_state", state, 3'd0);
        check("rst_mid_ram", disp_ram, 128'h0);
        check("rst_mid_ctrl", {disp_on, disp_bright, dio_out, frame_done}, 6'h0);
        stb_in = 1'b1;
        clk_in = 1'b1;
        #50;
        rst = 1'b0;
        #300;
        check("rst_mid_no_pulse", fd_cnt - fd_base, 0);
        check("rst_mid_idle", state, 3'd0);

        // Mode after reset is write/auto-increment without a data command.
        frame_start();
        send_bits(8'hC0, 8);
        send_bits(8'h77, 8);
        send_bits(8'h66, 8);
        frame_end();
        check("post_rst_write", disp_ram, {112'h0, 8'h66, 8'h77});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/tm1638_responder.md
TM1638_RESPONDER -- requirements
Module: tm1638_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2: input synchronizer depth on stb_in/clk_in/dio_in, legal 2..3.
REQ-002 mclk  input  1  system clock; every flop on its rising edge; at least 8x clk_in frequency.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 stb_in  input  1  TM1638 STB from host, active-low frame select.
REQ-005 clk_in  input  1  TM1638 serial clock from host.
REQ-006 dio_in  input  1  serial data from host, LSB first.
REQ-007 dio_out  output  1  serial read data to host.
REQ-008 dio_oe  output  1  high while responder drives DIO.
REQ-009 key_data  input  32  key-scan bytes; byte k = key_data[8k+7:8k], byte 0 sent first.
REQ-010 disp_ram  output  128  display RAM; address n = disp_ram[8n+7:8n].
REQ-011 disp_on  output  1  display-on bit from the last display-control command.
REQ-012 disp_bright  output  3  brightness from the last display-control command.
REQ-013 frame_done  output  1  one-mclk pulse at each frame end.
REQ-014 state  output  3  current FSM state, debug only.

Function
REQ-015 Sync inputs through SYNC_STAGES flops; detect clk_in rise/fall and stb_in rise/fall on the synchronized signals.
REQ-016 FSM states: IDLE=0, CMD=1, WDATA=2, RDATA=3, IGNORE=4.
REQ-017 IDLE->CMD on stb fall; clear bit counter and shift register.
REQ-018 In CMD/WDATA, shift dio_in in LSB-first on each clk rise; the byte completes on the 8th rise and acts one mclk later.
REQ-019 Command byte [7:6]=01 (data set): latch mode bit1 (1=read) and bit2 (fixed address); read->RDATA, write->IGNORE until stb rise.
REQ-020 Command byte [7:6]=10 (display control): disp_on<=bit3, disp_bright<=bits[2:0]; ->IGNORE.
REQ-021 Command byte [7:6]=11 (address set): addr<=bits[3:0]; ->WDATA only if latched mode is write, else IGNORE.
REQ-022 Command byte [7:6]=00: ->IGNORE, no register change.
REQ-023 WDATA: each completed byte writes disp_ram[addr]; addr then increments mod 16 (0xF wraps to 0x0), unless fixed mode is enabled (REQ-033).
REQ-024 RDATA: on the first clk fall after the command byte, assert dio_oe and drive bit 0 of the key byte; advance one bit per clk fall; 32 bits total.
REQ-025 key_data is captured into a 32-bit register at entry to RDATA; later key_data changes do not affect the frame.
REQ-026 After bit 31, release dio_oe on the next clk fall; further clocks drive nothing.
REQ-027 stb rise in any non-IDLE state: ->IDLE, dio_oe<=0, discard any partial byte, pulse frame_done.
REQ-028 stb rise and clk edge in the same mclk: stb rise wins; the clk edge is ignored.
REQ-029 dio_out is 0 whenever dio_oe is 0.
REQ-030 The data-set mode bits persist across frames until the next data-set command; the reset mode is write with auto-increment.

Reset
REQ-031 On rst: state=IDLE, dio_oe=0, dio_out=0, disp_ram=0, disp_on=0, disp_bright=0, frame_done=0, addr=0, mode=write/auto-increment, synchronizers preset to 1 on stb/clk and 0 on dio.
REQ-032 rst asserted mid-frame aborts the frame at once with no frame_done pulse; after release, the block waits in IDLE for a new stb fall.

Configuration
REQ-033 Macro TM1638_RESP_FIXED_ADDR_EN defined: data-command bit2=1 holds addr constant across WDATA bytes. Undefined: bit2 is ignored and addr always auto-increments.

Verification
REQ-034 Frame 0x40, then frame 0xC0 + 16 bytes 0x00..0x0F -> disp_ram byte n = n, 16 writes, frame_done pulses twice.
REQ-035 Frame 0x8F -> disp_on=1, disp_bright=7, disp_ram unchanged, dio_oe never high.
REQ-036 key_data=0x8040_2001, frame 0x42 + 32 clocks -> host samples bytes 01,20,40,80 LSB-first; dio_oe drops after bit 31.
REQ-037 Frame 0x40 then 0xCE + 3 bytes AA,BB,CC -> addr E=AA, F=BB, 0=CC (wraparound).
REQ-038 Frame 0x44, then frame 0xC3 + bytes 11,22 -> with the macro defined, addr 3=22; undefined, addr 3=11 and addr 4=22.
REQ-039 stb rises after 5 bits of a data byte -> no RAM write, frame_done pulses; rst mid-RDATA -> dio_oe=0 and all outputs at reset values within one mclk.
